apb_master_mc: RTL and testbench



---
 rtl/apb_master_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_apb_master_mc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_mc.sv
// apb_master_mc: multi-slave APB4-subset master bridge.
// Accepts one read/write command at a time. It decodes the target slave from
// the address and runs a single SETUP/ACCESS transfer with one-hot PSEL. The
// read data, slave error and timeout status come back on a valid/ready
// response port. Every APB and response output comes straight from a flop.
module apb_master_mc #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int SLV_AW  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    // command port
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    input  logic [DATA_W/8-1:0]      cmd_strb,
    // response port
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    // APB bus
    output logic [NSLV-1:0]          PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    output logic [DATA_W/8-1:0]      PSTRB,
    input  logic [NSLV*DATA_W-1:0]   PRDATA,
    input  logic [NSLV-1:0]          PREADY,
    input  logic [NSLV-1:0]          PSLVERR
);

    localparam int IDX_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // NSLV widened by one bit so that NSLV == 2**IDX_W still compares correctly
    localparam logic [IDX_W:0]   NSLV_L    = (IDX_W + 1)'(NSLV);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam bit               TO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_r,       state_nxt_s;
    logic [IDX_W-1:0]    idx_r,         idx_nxt_s;
    logic [CNT_W-1:0]    wait_cnt_r,    wait_cnt_nxt_s;
    logic [NSLV-1:0]     psel_r,        psel_nxt_s;
    logic                penable_r,     penable_nxt_s;
    logic                pwrite_r,      pwrite_nxt_s;
    logic [ADDR_W-1:0]   paddr_r,       paddr_nxt_s;
    logic [DATA_W-1:0]   pwdata_r,      pwdata_nxt_s;
    logic [STRB_W-1:0]   pstrb_r,       pstrb_nxt_s;
    logic                rsp_valid_r,   rsp_valid_nxt_s;
    logic [DATA_W-1:0]   rsp_rdata_r,   rsp_rdata_nxt_s;
    logic                rsp_err_r,     rsp_err_nxt_s;
    logic                rsp_timeout_r, rsp_timeout_nxt_s;

    logic [IDX_W-1:0]    cmd_idx_s;
    logic                cmd_idx_ok_s;
    logic [NSLV-1:0]     cmd_onehot_s;
    logic                sel_ready_s;
    logic                sel_err_s;
    logic [DATA_W-1:0]   sel_rdata_s;

    assign cmd_idx_s    = cmd_addr[SLV_AW +: IDX_W];
    assign cmd_idx_ok_s = ({1'b0, cmd_idx_s} < NSLV_L);

    // Decode the one-hot select for an incoming command.
    always_comb begin
        cmd_onehot_s = {NSLV{1'b0}};
        for (int k = 0; k < NSLV; k++) begin
            cmd_onehot_s[k] = (cmd_idx_s == IDX_W'(k));
        end
    end

    // AND-OR mux of the selected slave's returns; other slaves are ignored.
    always_comb begin
        sel_ready_s = 1'b0;
        sel_err_s   = 1'b0;
        sel_rdata_s = {DATA_W{1'b0}};
        for (int k = 0; k < NSLV; k++) begin
            sel_ready_s = sel_ready_s | (PREADY[k]  & (idx_r == IDX_W'(k)));
            sel_err_s   = sel_err_s   | (PSLVERR[k] & (idx_r == IDX_W'(k)));
            sel_rdata_s = sel_rdata_s |
                          (PRDATA[k*DATA_W +: DATA_W] & {DATA_W{idx_r == IDX_W'(k)}});
        end
    end

    // Next-state and next-output logic; by default every register holds.
    always_comb begin
        state_nxt_s       = state_r;
        idx_nxt_s         = idx_r;
        wait_cnt_nxt_s    = wait_cnt_r;
        psel_nxt_s        = psel_r;
        penable_nxt_s     = penable_r;
        pwrite_nxt_s      = pwrite_r;
        paddr_nxt_s       = paddr_r;
        pwdata_nxt_s      = pwdata_r;
        pstrb_nxt_s       = pstrb_r;
        rsp_valid_nxt_s   = rsp_valid_r;
        rsp_rdata_nxt_s   = rsp_rdata_r;
        rsp_err_nxt_s     = rsp_err_r;
        rsp_timeout_nxt_s = rsp_timeout_r;

        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_nxt_s    = cmd_addr;
                    pwrite_nxt_s   = cmd_write;
                    pwdata_nxt_s   = cmd_wdata;
                    pstrb_nxt_s    = cmd_write ? cmd_strb : {STRB_W{1'b0}};
                    idx_nxt_s      = cmd_idx_s;
                    wait_cnt_nxt_s = {CNT_W{1'b0}};
                    if (cmd_idx_ok_s) begin
                        psel_nxt_s  = cmd_onehot_s;
                        state_nxt_s = ST_SETUP;
                    end else begin
                        // decode error: answer at once without touching the bus
                        rsp_valid_nxt_s   = 1'b1;
                        rsp_err_nxt_s     = 1'b1;
                        rsp_timeout_nxt_s = 1'b0;
                        rsp_rdata_nxt_s   = {DATA_W{1'b0}};
                        state_nxt_s       = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_SETUP: begin
                penable_nxt_s = 1'b1;
                state_nxt_s   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (sel_ready_s) begin
                    psel_nxt_s        = {NSLV{1'b0}};
                    penable_nxt_s     = 1'b0;
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_err_nxt_s     = sel_err_s;
                    rsp_timeout_nxt_s = 1'b0;
                    rsp_rdata_nxt_s   = pwrite_r ? {DATA_W{1'b0}} : sel_rdata_s;
                    state_nxt_s       = ST_RESP;
                end else if (TO_EN && (wait_cnt_r == CNT_LIMIT)) begin
                    psel_nxt_s        = {NSLV{1'b0}};
                    penable_nxt_s     = 1'b0;
                    rsp_valid_nxt_s   = 1'b1;
                    rsp_err_nxt_s     = 1'b1;
                    rsp_timeout_nxt_s = 1'b1;
                    rsp_rdata_nxt_s   = {DATA_W{1'b0}};
                    state_nxt_s       = ST_RESP;
                end else begin
                    // saturating count of PREADY-low cycles
                    wait_cnt_nxt_s = (wait_cnt_r == CNT_MAX) ? wait_cnt_r
                                                             : wait_cnt_r + CNT_W'(1);
                    state_nxt_s    = ST_ACCESS;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end

            default: begin
                psel_nxt_s      = {NSLV{1'b0}};
                penable_nxt_s   = 1'b0;
                rsp_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bus and drops any response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            wait_cnt_r    <= {CNT_W{1'b0}};
            psel_r        <= {NSLV{1'b0}};
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_W{1'b0}};
            pwdata_r      <= {DATA_W{1'b0}};
            pstrb_r       <= {STRB_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            idx_r         <= idx_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            psel_r        <= psel_nxt_s;
            penable_r     <= penable_nxt_s;
            pwrite_r      <= pwrite_nxt_s;
            paddr_r       <= paddr_nxt_s;
            pwdata_r      <= pwdata_nxt_s;
            pstrb_r       <= pstrb_nxt_s;
            rsp_valid_r   <= rsp_valid_nxt_s;
            rsp_rdata_r   <= rsp_rdata_nxt_s;
            rsp_err_r     <= rsp_err_nxt_s;
            rsp_timeout_r <= rsp_timeout_nxt_s;
        end
    end

    assign cmd_ready   = (state_r == ST_IDLE);
    assign PSEL        = psel_r;
    assign PENABLE     = penable_r;
    assign PWRITE      = pwrite_r;
    assign PADDR       = paddr_r;
    assign PWDATA      = pwdata_r;
    assign PSTRB       = pstrb_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_mc.sv
// tb_apb_master_mc: directed bench for apb_master_mc with a response scoreboard.
// The stimulus pushes the expected response for each command. The monitor pops
// and compares an entry on every rsp handshake. The stimulus thread also checks
// bus timing.
module tb_apb_master_mc;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int NSLV   = 3;

    logic                   PCLK = 1'b0;
    logic                   PRESET;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [DATA_W-1:0]      cmd_wdata;
    logic [DATA_W/8-1:0]    cmd_strb;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   rsp_timeout;
    logic [NSLV-1:0]        PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [ADDR_W-1:0]      PADDR;
    logic [DATA_W-1:0]      PWDATA;
    logic [DATA_W/8-1:0]    PSTRB;
    logic [NSLV*DATA_W-1:0] PRDATA;
    logic [NSLV-1:0]        PREADY;
    logic [NSLV-1:0]        PSLVERR;

    apb_master_mc #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .SLV_AW(12), .TIMEOUT(15)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // ---------------- slave models ----------------
    // slv_wait[k]: PREADY-low ACCESS cycles before ready (-1 = never ready)
    int              slv_wait [NSLV];
    logic [DATA_W-1:0] slv_rdata [NSLV];
    logic [NSLV-1:0] slv_err;
    int              acc_cycles = 0;

    // Count completed ACCESS cycles of the current transfer.
    always @(posedge PCLK) begin
        if (PENABLE && (PSEL != 3'b000)) acc_cycles <= acc_cycles + 1;
        else                             acc_cycles <= 0;
    end

    // Drive every slave's ready/error/data from its configuration.
    always_comb begin
        PREADY  = 3'b000;
        PSLVERR = 3'b000;
        PRDATA  = {(NSLV*DATA_W){1'b0}};
        for (int k = 0; k < NSLV; k++) begin
            PREADY[k]  = (slv_wait[k] >= 0) && (acc_cycles >= slv_wait[k]);
            PSLVERR[k] = slv_err[k];
            PRDATA[k*DATA_W +: DATA_W] = slv_rdata[k];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              to;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] rd, input logic er, input logic to);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    // Compare each handshaken response with the oldest expected entry.
    always @(negedge PCLK) begin
        if (!PRESET && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got response rdata=0x%0h err=%0b, expected none",
                         rsp_rdata, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata",   rsp_rdata,   mon_e.rdata);
                chk("rsp_err",     rsp_err,     mon_e.err);
                chk("rsp_timeout", rsp_timeout, mon_e.to);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command in the current cycle; returns one cycle after acceptance.
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        chk("cmd_ready_at_issue", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Bound the whole run in case the DUT hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 32'h0;
        cmd_strb  = 4'h0;
        rsp_ready = 1'b1;
        for (int k = 0; k < NSLV; k++) begin
            slv_wait[k]  = 0;
            slv_rdata[k] = 32'hA0A0_0000 + k;
        end
        slv_err = 3'b000;

        // reset state
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_psel",      PSEL,        3'b000);
        chk("rst_penable",   PENABLE,     1'b0);
        chk("rst_pwrite",    PWRITE,      1'b0);
        chk("rst_paddr",     PADDR,       16'h0000);
        chk("rst_pwdata",    PWDATA,      32'h0);
        chk("rst_pstrb",     PSTRB,       4'h0);
        chk("rst_rsp_valid", rsp_valid,   1'b0);
        chk("rst_rsp_rdata", rsp_rdata,   32'h0);
        chk("rst_rsp_err",   rsp_err,     1'b0);
        chk("rst_rsp_to",    rsp_timeout, 1'b0);
        chk("rst_cmd_ready", cmd_ready,   1'b1);
        PRESET = 1'b0;
        tick();

        // 1: write slave 1, zero wait; slave 0 erroring in the background is ignored
        slv_err = 3'b001;
        push_exp(32'h0, 1'b0, 1'b0);
        issue(1'b1, 16'h1004, 32'hDEADBEEF, 4'hF);
        chk("t1_setup_psel",    PSEL,    3'b010);
        chk("t1_setup_penable", PENABLE, 1'b0);
        chk("t1_paddr",         PADDR,   16'h1004);
        chk("t1_pwdata",        PWDATA,  32'hDEADBEEF);
        chk("t1_pwrite",        PWRITE,  1'b1);
        chk("t1_pstrb",         PSTRB,   4'hF);
        chk("t1_cmd_ready_busy", cmd_ready, 1'b0);
        tick();
        chk("t1_access_psel",    PSEL,    3'b010);
        chk("t1_access_penable", PENABLE, 1'b1);
        tick();
        chk("t1_rsp_valid_n3",   rsp_valid, 1'b1);
        chk("t1_resp_psel",      PSEL,      3'b000);
        chk("t1_resp_penable",   PENABLE,   1'b0);
        tick();
        chk("t1_cmd_ready_n4",   cmd_ready, 1'b1);
        chk("t1_rsp_valid_1cyc", rsp_valid, 1'b0);
        slv_err = 3'b000;

        // 2: read slave 2 with 3 wait cycles; strobes must be zeroed for reads
        slv_wait[2]  = 3;
        slv_rdata[2] = 32'h12345678;
        push_exp(32'h12345678, 1'b0, 1'b0);
        issue(1'b0, 16'h2010, 32'h5555_AAAA, 4'hF);
        chk("t2_setup_psel", PSEL,   3'b100);
        chk("t2_pstrb",      PSTRB,  4'h0);
        chk("t2_pwrite",     PWRITE, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_access_penable", PENABLE,   1'b1);
            chk("t2_access_paddr",   PADDR,     16'h2010);
            chk("t2_no_rsp_yet",     rsp_valid, 1'b0);
        end
        tick();
        chk("t2_rsp_valid_n6", rsp_valid, 1'b1);
        tick();
        slv_wait[2] = 0;

        // 3: write slave 0 with PSLVERR
        slv_err = 3'b001;
        push_exp(32'h0, 1'b1, 1'b0);
        issue(1'b1, 16'h0008, 32'h0000_00FF, 4'h1);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        chk("t3_rsp_seen", rsp_valid, 1'b1);
        tick();
        chk("t3_back_to_idle", cmd_ready, 1'b1);
        slv_err = 3'b000;

        // 4: read slave 1 stuck low -> timeout after 16 ACCESS cycles
        slv_wait[1]  = -1;
        slv_rdata[1] = 32'hBADC0FFE;
        push_exp(32'h0, 1'b1, 1'b1);
        issue(1'b0, 16'h1000, 32'h0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t4_access_psel",    PSEL,      3'b010);
            chk("t4_access_penable", PENABLE,   1'b1);
            chk("t4_no_rsp_yet",     rsp_valid, 1'b0);
        end
        tick();
        chk("t4_rsp_valid",  rsp_valid, 1'b1);
        chk("t4_psel_drop",  PSEL,      3'b000);
        tick();
        slv_wait[1] = 0;

        // 5: decode error at index 3
        push_exp(32'h0, 1'b1, 1'b0);
        issue(1'b0, 16'h3000, 32'h0, 4'h0);
        chk("t5_rsp_valid_n1", rsp_valid, 1'b1);
        chk("t5_psel_zero",    PSEL,      3'b000);
        chk("t5_penable_zero", PENABLE,   1'b0);
        tick();
        chk("t5_idle", cmd_ready, 1'b1);

        // 6: response back-pressure for 5 cycles
        rsp_ready    = 1'b0;
        slv_rdata[2] = 32'hCAFEF00D;
        push_exp(32'hCAFEF00D, 1'b0, 1'b0);
        issue(1'b0, 16'h2000, 32'h0, 4'h0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_valid",     rsp_valid, 1'b1);
            chk("t6_hold_rdata",     rsp_rdata, 32'hCAFEF00D);
            chk("t6_hold_err",       rsp_err,   1'b0);
            chk("t6_cmd_ready_low",  cmd_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t6_idle", cmd_ready, 1'b1);

        // 7: reset during ACCESS discards the transfer
        slv_wait[2] = -1;
        issue(1'b0, 16'h2004, 32'h0, 4'h0);
        tick();
        chk("t7_in_access", PENABLE, 1'b1);
        PRESET = 1'b1;
        #1;
        chk("t7_rst_psel",      PSEL,      3'b000);
        chk("t7_rst_penable",   PENABLE,   1'b0);
        chk("t7_rst_rsp_valid", rsp_valid, 1'b0);
        tick();
        PRESET = 1'b0;
        tick();
        chk("t7_cmd_ready_after", cmd_ready, 1'b1);
        chk("t7_no_rsp_after",    rsp_valid, 1'b0);
        slv_wait[2] = 0;

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
